// File: rtl/fft_stage_sequencer.sv
// Address and twiddle sequencer for an in-place radix-2 DIT FFT.
// Issues one butterfly read pair per cycle and delays each pair by the
// datapath latency to form its write-back. Between stages it drains the
// pipeline so the next stage never reads a location with a pending write.
module fft_stage_sequencer #(
  parameter int LOG2N    = 4,
  parameter int PIPE_LAT = 18
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_hold,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [$clog2(LOG2N):0] o_stage,
  output logic                   o_rd_en,
  output logic [LOG2N-1:0]       o_rd_addr_a,
  output logic [LOG2N-1:0]       o_rd_addr_b,
  output logic [LOG2N-2:0]       o_tw_idx,
  output logic                   o_wr_en,
  output logic [LOG2N-1:0]       o_wr_addr_a,
  output logic [LOG2N-1:0]       o_wr_addr_b
);

  localparam int SW = $clog2(LOG2N) + 1;
  localparam int KW = LOG2N - 1;
  localparam int IW = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [KW-1:0]     k;
  logic [IW-1:0]     inflight;
  logic [IW-1:0]     inflight_next;
  logic              last_stage;

  logic [KW-1:0]     gen_k;
  logic [SW-1:0]     gen_s;
  logic [LOG2N-1:0]  kk;
  logic [LOG2N-1:0]  mask;
  logic [LOG2N-1:0]  pos;
  logic [LOG2N-1:0]  gen_a;
  logic [LOG2N-1:0]  gen_b;
  logic [LOG2N-1:0]  tw_full;
  logic [KW-1:0]     gen_tw;

  logic              sr_v [PIPE_LAT];
  logic [LOG2N-1:0]  sr_a [PIPE_LAT];
  logic [LOG2N-1:0]  sr_b [PIPE_LAT];

  // Butterfly to be issued at the next edge; on the entry edges of a stage
  // (start, or drain completion) it is k=0 of the stage being entered.
  always_comb begin
    gen_k = '0;
    gen_s = '0;
    case (state)
      S_ISSUE: begin
        gen_k = k;
        gen_s = o_stage;
      end
      S_DRAIN: gen_s = o_stage + 1'b1;
      default: ;
    endcase
    kk      = {1'b0, gen_k};
    mask    = (LOG2N'(1) << gen_s) - LOG2N'(1);
    pos     = kk & mask;
    gen_a   = ((kk >> gen_s) << (gen_s + SW'(1))) | pos;
    gen_b   = gen_a + (LOG2N'(1) << gen_s);
    tw_full = pos << (SW'(LOG2N - 1) - gen_s);
    gen_tw  = tw_full[KW-1:0];
  end

  // Pending-write bookkeeping and final-stage flag
  always_comb begin
    inflight_next = inflight + IW'(o_rd_en) - IW'(o_wr_en);
    last_stage    = (o_stage == SW'(LOG2N - 1));
  end

  // Control FSM with registered outputs and issue counter
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= S_IDLE;
      k           <= '0;
      inflight    <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_stage     <= '0;
      o_rd_en     <= 1'b0;
      o_rd_addr_a <= '0;
      o_rd_addr_b <= '0;
      o_tw_idx    <= '0;
    end else begin
      o_rd_en  <= 1'b0;
      o_done   <= 1'b0;
      inflight <= inflight_next;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state   <= S_ISSUE;
            o_busy  <= 1'b1;
            o_stage <= '0;
            k       <= '0;
            if (!i_hold) begin
              o_rd_en     <= 1'b1;
              o_rd_addr_a <= gen_a;
              o_rd_addr_b <= gen_b;
              o_tw_idx    <= gen_tw;
              k           <= KW'(1);
            end
          end
        end
        S_ISSUE: begin
          if (!i_hold) begin
            o_rd_en     <= 1'b1;
            o_rd_addr_a <= gen_a;
            o_rd_addr_b <= gen_b;
            o_tw_idx    <= gen_tw;
            k           <= k + 1'b1;
            if (k == '1) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The edge retiring the last write also issues the next stage's
          // first butterfly, so no idle cycle separates the stages.
          if (inflight_next == '0) begin
            if (last_stage) begin
              state  <= S_DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else begin
              state   <= S_ISSUE;
              o_stage <= o_stage + 1'b1;
              k       <= '0;
              if (!i_hold) begin
                o_rd_en     <= 1'b1;
                o_rd_addr_a <= gen_a;
                o_rd_addr_b <= gen_b;
                o_tw_idx    <= gen_tw;
                k           <= KW'(1);
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write-back delay line; free-running, fed from the registered read pair
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        sr_v[i] <= 1'b0;
        sr_a[i] <= '0;
        sr_b[i] <= '0;
      end
    end else begin
      sr_v[0] <= o_rd_en;
      sr_a[0] <= o_rd_addr_a;
      sr_b[0] <= o_rd_addr_b;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        sr_v[i] <= sr_v[i-1];
        sr_a[i] <= sr_a[i-1];
        sr_b[i] <= sr_b[i-1];
      end
    end
  end

  assign o_wr_en     = sr_v[PIPE_LAT-1];
  assign o_wr_addr_a = sr_a[PIPE_LAT-1];
  assign o_wr_addr_b = sr_b[PIPE_LAT-1];

endmodule
